// File: rtl/reg_file_np.sv
// WIDTH x DEPTH register bank: one write port, two registered read ports with write-through,
// per-entry valid bits, optional hardwired-zero entry 0 and synchronous bulk clear.
module reg_file_np #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clkpos,
    input  logic             rstneg,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             vld_q [DEPTH];
    logic             vld_d [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic             rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;

    // Reads see the post-edge entry contents, so a coincident write or clear is forwarded.
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (ZERO_REG == 1 && i == 0) begin
                mem_d[i] = '0;
                vld_d[i] = 1'b1;
            end else if (we && waddr == AW'(i)) begin
                mem_d[i] = wdata;
                vld_d[i] = 1'b1;
            end else if (clr) begin
                mem_d[i] = '0;
                vld_d[i] = 1'b0;
            end
        end

        rdata_a_d  = rdata_a_q;
        rvalid_a_d = rvalid_a_q;
        if (re_a) begin
            if ({1'b0, raddr_a} < DEPTH_W) begin
                rdata_a_d  = mem_d[raddr_a];
                rvalid_a_d = vld_d[raddr_a];
            end else begin
                rdata_a_d  = '0;
                rvalid_a_d = 1'b0;
            end
        end

        rdata_b_d  = rdata_b_q;
        rvalid_b_d = rvalid_b_q;
        if (re_b) begin
            if ({1'b0, raddr_b} < DEPTH_W) begin
                rdata_b_d  = mem_d[raddr_b];
                rvalid_b_d = vld_d[raddr_b];
            end else begin
                rdata_b_d  = '0;
                rvalid_b_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clkpos or negedge rstneg) begin
        if (!rstneg) begin
            mem_q      <= '{default: '0};
            vld_q      <= '{default: 1'b0};
            rdata_a_q  <= '0;
            rvalid_a_q <= 1'b0;
            rdata_b_q  <= '0;
            rvalid_b_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            vld_q      <= vld_d;
            rdata_a_q  <= rdata_a_d;
            rvalid_a_q <= rvalid_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign rdata_a  = rdata_a_q;
    assign rvalid_a = rvalid_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_b = rvalid_b_q;

endmodule
